regfile_port_arbiter: RTL and testbench
=======================================

# regfile_port_arbiter

Shares the single-ported 32x16 register file (ports Ra/Rb/Rw/WrEn/busW in, registered busA/busB out) between two requesters: execute writeback/operand fetch (requester 0) and the debug/load unit (requester 1). Arbitrates one transaction per cycle with round-robin fairness and drives the register file address, write-enable and write-data inputs. Routes the returned read data back to the owning requester with a valid strobe. Also sequences a 32-cycle zero-fill of the register file after reset and on request.

## Interface
- DW, 16, data width; matches register file word.
- AW, 5, register address width; depth = 2**AW = 32.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- clr  in  1  one-cycle pulse; starts a zero-fill sequence.
- req0 / req1  in  1  transaction request; held until granted.
- ra0, rb0 / ra1, rb1  in  AW  read addresses.
- rw0 / rw1  in  AW  write address.
- we0 / we1  in  1  write enable qualifier for the transaction.
- wd0 / wd1  in  DW  write data.
- gnt0 / gnt1  out  1  grant; combinational, same cycle as accepted req.
- rvalid0 / rvalid1  out  1  read data valid for that requester; registered.
- rdata_a, rdata_b  out  DW  read data, shared by both requesters; qualified by rvalid0/1.
- busy  out  1  high while zero-fill runs; no grants issued.
- rf_ra, rf_rb, rf_rw  out  AW  to register file Ra/Rb/Rw.
- rf_we  out  1  to register file WrEn.
- rf_busw  out  DW  to register file busW.
- rf_busa, rf_busb  in  DW  from register file busA/busB.

## Operation
- States: CLEAR, ACTIVE. Reset state CLEAR, fill counter cnt = 0.
- CLEAR: rf_we=1, rf_rw=cnt, rf_busw=0, rf_ra=rf_rb=0; gnt0=gnt1=0; busy=1. cnt increments each cycle; at cnt=31 the write completes and the next state is ACTIVE, cnt returns to 0.
- ACTIVE: busy=0. Exactly one grant when any req is high.
  - Only one req high: grant it.
  - Both high: grant the requester not granted most recently (last pointer). Reset value of last = 1, so requester 0 wins the first tie.
  - last updates to the granted index on every grant; unchanged on idle cycles.
- Granted transaction drives rf_ra/rf_rb/rf_rw/rf_busw from that requester; rf_we = gnt & we. No grant: rf_we=0, addresses and data hold 0.
- rvalidN registered from gntN; rdata_a/rdata_b = rf_busa/rf_busb passthrough. Same-address read/write forwarding is the register file's job; the arbiter adds none.
- clr high in ACTIVE: the grant in that cycle still completes; CLEAR begins next cycle at cnt=0. clr during CLEAR is ignored.
- Requests are not queued. A requester not granted keeps req and its fields stable.
- Reset outputs: gnt0=gnt1=0, rvalid0=rvalid1=0, busy=1, rf_we=1, rf_rw=0, rf_busw=0, rf_ra=rf_rb=0.

## Timing
- Clear duration: 32 cycles (cnt 0..31). The first grant can occur in the 33rd cycle after rst deasserts.
- Grant latency: 0 cycles (same-cycle combinational).
- Read latency: rvalid and data are valid 1 cycle after gnt, for one cycle only.
- Throughput: 1 transaction/cycle. Under continuous dual requests grants alternate 0,1,0,1.
- rst asserted mid-transaction: rvalid clears immediately (async). A pending rvalid is lost, and the state returns to CLEAR with cnt=0.
- rvalid from the final ACTIVE grant before a clr still fires in the first CLEAR cycle.

## Structure
- Shared package rf_pkg: RF_DW, RF_AW, RF_DEPTH constants; state enum {CLEAR, ACTIVE}.
- One sub-module, rr_arb2: 2-way round-robin with the last pointer. Inputs req[1:0] and enable; outputs one-hot gnt[1:0]. Holds the pointer flop.
- The top level holds the FSM, fill counter, rvalid flops and the rf_* muxing.

## Test plan
- Reset then idle: busy=1 for 32 cycles with rf_rw stepping 0..31 and rf_we=1. Then busy=0, and a read of r31 returns rvalid0=1, rdata_a=0.
- req0 write r5=0xBEEF, then req0 read ra=5: rvalid0 one cycle after the second grant, rdata_a=0xBEEF.
- req0 and req1 both held 4 cycles: gnt order 0,1,0,1. rvalid follows each grant by 1 cycle on the matching requester only.
- Same-cycle write r7=0x1234 and read ra=7 from one requester: rdata_a=0x1234 next cycle, via register file forwarding.
- clr pulse while req1 is granted: that grant's rvalid1 fires, then busy=1 for 32 cycles with no grants. A subsequent read of r5 returns 0.
- Async rst asserted in the cycle after a grant: rvalid stays 0, and busy=1 immediately without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_port_arbiter_pkg.sv
// Shared constants and types for the register-file port arbiter.
// Holds the register-file geometry, the FSM state type and the per-requester transaction bundle.
package rf_pkg;

    localparam int unsigned RF_DW    = 16;
    localparam int unsigned RF_AW    = 5;
    localparam int unsigned RF_DEPTH = 2 ** RF_AW;

    typedef enum logic {
        CLEAR,
        ACTIVE
    } state_e;

    typedef struct packed {
        logic [RF_AW-1:0] ra;
        logic [RF_AW-1:0] rb;
        logic [RF_AW-1:0] rw;
        logic             we;
        logic [RF_DW-1:0] wd;
    } rf_txn_t;

    function automatic rf_txn_t mk_txn(
        input logic [RF_AW-1:0] ra,
        input logic [RF_AW-1:0] rb,
        input logic [RF_AW-1:0] rw,
        input logic             we,
        input logic [RF_DW-1:0] wd
    );
        rf_txn_t t;
        t.ra = ra;
        t.rb = rb;
        t.rw = rw;
        t.we = we;
        t.wd = wd;
        return t;
    endfunction

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Bundle of requester, control and register-file signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface regfile_port_arbiter_if
    import rf_pkg::*;
#(
    parameter int unsigned DW = RF_DW,
    parameter int unsigned AW = RF_AW
) ();

    logic          clr;
    logic          busy;

    logic          req0;
    logic [AW-1:0] ra0;
    logic [AW-1:0] rb0;
    logic [AW-1:0] rw0;
    logic          we0;
    logic [DW-1:0] wd0;
    logic          gnt0;
    logic          rvalid0;

    logic          req1;
    logic [AW-1:0] ra1;
    logic [AW-1:0] rb1;
    logic [AW-1:0] rw1;
    logic          we1;
    logic [DW-1:0] wd1;
    logic          gnt1;
    logic          rvalid1;

    logic [DW-1:0] rdata_a;
    logic [DW-1:0] rdata_b;

    logic [AW-1:0] rf_ra;
    logic [AW-1:0] rf_rb;
    logic [AW-1:0] rf_rw;
    logic          rf_we;
    logic [DW-1:0] rf_busw;
    logic [DW-1:0] rf_busa;
    logic [DW-1:0] rf_busb;

    modport slave (
        input  clr,
        input  req0, ra0, rb0, rw0, we0, wd0,
        input  req1, ra1, rb1, rw1, we1, wd1,
        input  rf_busa, rf_busb,
        output busy,
        output gnt0, rvalid0,
        output gnt1, rvalid1,
        output rdata_a, rdata_b,
        output rf_ra, rf_rb, rf_rw, rf_we, rf_busw
    );

    modport master (
        output clr,
        output req0, ra0, rb0, rw0, we0, wd0,
        output req1, ra1, rb1, rw1, we1, wd1,
        output rf_busa, rf_busb,
        input  busy,
        input  gnt0, rvalid0,
        input  gnt1, rvalid1,
        input  rdata_a, rdata_b,
        input  rf_ra, rf_rb, rf_rw, rf_we, rf_busw
    );

endinterface

// File: rtl/regfile_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to the requester not granted most recently.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt
);

    // Index of the most recent grant; reset to 1 so requester 0 wins the first tie.
    logic r_last;

    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            unique case (i_req)
                2'b01:   o_gnt = 2'b01;
                2'b10:   o_gnt = 2'b10;
                2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
                default: o_gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (|o_gnt) begin
            r_last <= o_gnt[1];
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares a single-ported 32x16 register file between two requesters and zero-fills it
// after reset or on a clr pulse.
module regfile_port_arbiter
    import rf_pkg::*;
(
    input logic                   clk,
    input logic                   rst,
    regfile_port_arbiter_if.slave bus
);

    localparam logic [RF_AW-1:0] LAST_ADDR = RF_AW'(RF_DEPTH - 1);

    state_e           r_state;
    logic [RF_AW-1:0] r_cnt;
    logic             r_rvalid0;
    logic             r_rvalid1;

    logic [1:0]       w_req;
    logic [1:0]       w_gnt;
    logic             w_arb_en;
    rf_txn_t          w_txn0;
    rf_txn_t          w_txn1;
    rf_txn_t          w_sel;

    assign w_arb_en = (r_state == ACTIVE);
    assign w_req    = {bus.req1, bus.req0};
    assign w_txn0   = mk_txn(bus.ra0, bus.rb0, bus.rw0, bus.we0, bus.wd0);
    assign w_txn1   = mk_txn(bus.ra1, bus.rb1, bus.rw1, bus.we1, bus.wd1);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req (w_req),
        .i_en  (w_arb_en),
        .o_gnt (w_gnt)
    );

    // Fill counter wraps 31 -> 0 on its own, so leaving CLEAR needs no explicit reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= CLEAR;
            r_cnt     <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_gnt[0];
            r_rvalid1 <= w_gnt[1];
            case (r_state)
                CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ADDR) begin
                        r_state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (bus.clr) begin
                        r_state <= CLEAR;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= CLEAR;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // An idle cycle selects the all-zero bundle, which also forces rf_we low.
    always_comb begin
        w_sel = '0;
        unique case (w_gnt)
            2'b01:   w_sel = w_txn0;
            2'b10:   w_sel = w_txn1;
            default: w_sel = '0;
        endcase
    end

    always_comb begin
        bus.rf_ra   = '0;
        bus.rf_rb   = '0;
        bus.rf_rw   = '0;
        bus.rf_we   = 1'b0;
        bus.rf_busw = '0;
        if (r_state == CLEAR) begin
            bus.rf_we = 1'b1;
            bus.rf_rw = r_cnt;
        end else begin
            bus.rf_ra   = w_sel.ra;
            bus.rf_rb   = w_sel.rb;
            bus.rf_rw   = w_sel.rw;
            bus.rf_we   = w_sel.we;
            bus.rf_busw = w_sel.wd;
        end
    end

    assign bus.gnt0    = w_gnt[0];
    assign bus.gnt1    = w_gnt[1];
    assign bus.rvalid0 = r_rvalid0;
    assign bus.rvalid1 = r_rvalid1;
    assign bus.rdata_a = bus.rf_busa;
    assign bus.rdata_b = bus.rf_busb;
    assign bus.busy    = (r_state == CLEAR);

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter with a behavioural register file attached and a
// reference model feeding a scoreboard queue of expected read returns.
module tb_regfile_port_arbiter;
    import rf_pkg::*;

    typedef struct {
        int          who;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_port_arbiter_if bus ();

    regfile_port_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register file: registered read ports with same-address write forwarding.
    logic [15:0] rf_mem [RF_DEPTH];
    always @(posedge clk) begin
        if (bus.rf_we) rf_mem[bus.rf_rw] <= bus.rf_busw;
        bus.rf_busa <= (bus.rf_we && bus.rf_rw == bus.rf_ra) ? bus.rf_busw : rf_mem[bus.rf_ra];
        bus.rf_busb <= (bus.rf_we && bus.rf_rw == bus.rf_rb) ? bus.rf_busw : rf_mem[bus.rf_rb];
    end

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        sb_q[$];
    logic [15:0] m_mem [RF_DEPTH];
    bit          m_clear = 1'b1;
    int          m_cnt = 0;
    int          m_last = 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic set_req(input int idx, input logic [4:0] ra, input logic [4:0] rb,
                           input logic [4:0] rw, input logic we, input logic [15:0] wd);
        if (idx == 0) begin
            bus.req0 = 1'b1; bus.ra0 = ra; bus.rb0 = rb; bus.rw0 = rw; bus.we0 = we; bus.wd0 = wd;
        end else begin
            bus.req1 = 1'b1; bus.ra1 = ra; bus.rb1 = rb; bus.rw1 = rw; bus.we1 = we; bus.wd1 = wd;
        end
    endtask

    task automatic drop_req(input int idx);
        if (idx == 0) bus.req0 = 1'b0;
        else bus.req1 = 1'b0;
    endtask

    function automatic logic [1:0] onehot(input int who);
        return (who == 0) ? 2'b01 : (who == 1) ? 2'b10 : 2'b00;
    endfunction

    // Called just after a falling edge with stimulus applied; returns after the next one.
    task automatic step();
        exp_t        e;
        int          g;
        logic [4:0]  ra, rb, rw;
        logic        we;
        logic [15:0] wd;
        #1;
        e.who = -1; e.a = '0; e.b = '0;
        if (m_clear) begin
            check_eq("clr_busy", bus.busy, 1);
            check_eq("clr_we", bus.rf_we, 1);
            check_eq("clr_rw", bus.rf_rw, m_cnt);
            check_eq("clr_busw", bus.rf_busw, 0);
            check_eq("clr_gnt", onehot(-1), {bus.gnt1, bus.gnt0});
            m_mem[m_cnt] = '0;
            if (m_cnt == 31) begin
                m_clear = 1'b0;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end else begin
            g = -1;
            if (bus.req0 && bus.req1) g = (m_last == 1) ? 0 : 1;
            else if (bus.req0) g = 0;
            else if (bus.req1) g = 1;
            check_eq("busy", bus.busy, 0);
            check_eq("gnt", {bus.gnt1, bus.gnt0}, onehot(g));
            if (g >= 0) begin
                m_last = g;
                if (g == 0) begin ra = bus.ra0; rb = bus.rb0; rw = bus.rw0; we = bus.we0; wd = bus.wd0; end
                else begin ra = bus.ra1; rb = bus.rb1; rw = bus.rw1; we = bus.we1; wd = bus.wd1; end
                check_eq("rf_we", bus.rf_we, we);
                check_eq("rf_ra", bus.rf_ra, ra);
                if (we) begin
                    check_eq("rf_rw", bus.rf_rw, rw);
                    check_eq("rf_busw", bus.rf_busw, wd);
                end
                e.who = g;
                e.a = (we && rw == ra) ? wd : m_mem[ra];
                e.b = (we && rw == rb) ? wd : m_mem[rb];
                if (we) m_mem[rw] = wd;
            end else begin
                check_eq("idle_we", bus.rf_we, 0);
            end
            if (bus.clr) begin
                m_clear = 1'b1;
                m_cnt = 0;
            end
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq("rvalid", {bus.rvalid1, bus.rvalid0}, onehot(e.who));
        if (e.who >= 0) begin
            check_eq("rdata_a", bus.rdata_a, e.a);
            check_eq("rdata_b", bus.rdata_b, e.b);
        end
        @(negedge clk);
    endtask

    initial begin
        bus.clr = 1'b0;
        bus.req0 = 1'b0; bus.ra0 = '0; bus.rb0 = '0; bus.rw0 = '0; bus.we0 = 1'b0; bus.wd0 = '0;
        bus.req1 = 1'b0; bus.ra1 = '0; bus.rb1 = '0; bus.rw1 = '0; bus.we1 = 1'b0; bus.wd1 = '0;

        // Reset values, with a request pending that must not be granted.
        bus.req0 = 1'b1;
        @(negedge clk);
        #1;
        check_eq("rst_gnt", {bus.gnt1, bus.gnt0}, 2'b00);
        check_eq("rst_rvalid", {bus.rvalid1, bus.rvalid0}, 2'b00);
        check_eq("rst_busy", bus.busy, 1);
        check_eq("rst_we", bus.rf_we, 1);
        check_eq("rst_rw", bus.rf_rw, 0);
        check_eq("rst_busw", bus.rf_busw, 0);
        check_eq("rst_rarb", {bus.rf_ra, bus.rf_rb}, 0);
        bus.req0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        repeat (32) step();
        set_req(0, 5'd31, 5'd31, 5'd0, 1'b0, 16'h0); step(); drop_req(0);

        set_req(0, 5'd0, 5'd0, 5'd5, 1'b1, 16'hBEEF); step();
        set_req(0, 5'd5, 5'd0, 5'd0, 1'b0, 16'h0); step(); drop_req(0);

        // Leave requester 1 as most recent so the tie run starts with 0.
        set_req(1, 5'd0, 5'd0, 5'd9, 1'b1, 16'h5A5A); step(); drop_req(1);
        set_req(0, 5'd5, 5'd9, 5'd0, 1'b0, 16'h0);
        set_req(1, 5'd9, 5'd5, 5'd0, 1'b0, 16'h0);
        repeat (4) step();
        drop_req(0); drop_req(1);

        set_req(1, 5'd7, 5'd5, 5'd7, 1'b1, 16'h1234); step(); drop_req(1);

        // clr alongside a requester-1 grant, then a held req0 across the whole fill.
        set_req(1, 5'd7, 5'd9, 5'd0, 1'b0, 16'h0);
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        drop_req(1);
        set_req(0, 5'd5, 5'd7, 5'd0, 1'b0, 16'h0);
        for (int i = 0; i < 32; i++) begin
            bus.clr = (i == 10);
            step();
        end
        bus.clr = 1'b0;
        step();
        drop_req(0);

        // Asynchronous reset in the cycle after a grant.
        set_req(0, 5'd7, 5'd5, 5'd0, 1'b0, 16'h0);
        #1;
        check_eq("ar_gnt", {bus.gnt1, bus.gnt0}, 2'b01);
        @(posedge clk);
        #1;
        check_eq("ar_rvalid_pre", {bus.rvalid1, bus.rvalid0}, 2'b01);
        check_eq("ar_rdata_pre", bus.rdata_a, m_mem[7]);
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_rvalid", {bus.rvalid1, bus.rvalid0}, 2'b00);
        check_eq("ar_busy", bus.busy, 1);
        check_eq("ar_gnt_off", {bus.gnt1, bus.gnt0}, 2'b00);
        drop_req(0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_clear = 1'b1;
        m_cnt = 0;
        m_last = 1;
        sb_q.delete();
        repeat (32) step();
        set_req(1, 5'd5, 5'd7, 5'd0, 1'b0, 16'h0); step(); drop_req(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
